// File: rtl/aes_pkg.sv
// Shared AES-128 constants, tables and byte-level helpers used by the round
// sequencer and its round-step datapath.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned ROUND_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for key-expansion step 1..10; zero outside that range.
    function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / ciphertext-out handshake bundle of the AES round sequencer.
interface aes_round_sequencer_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] datain;
    logic [BLOCK_W-1:0] key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] dataout;
    logic               busy;

    modport master (
        output in_valid, datain, key, out_ready,
        input  in_ready, out_valid, dataout, busy
    );

    modport slave (
        input  in_valid, datain, key, out_ready,
        output in_ready, out_valid, dataout, busy
    );

endinterface

// File: rtl/aes_round_step.sv
// One AES-128 encryption round plus the matching on-the-fly key-schedule step.
// Purely combinational; final_round drops MixColumns.
module aes_round_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_rkey,
    input  logic [ROUND_W-1:0] i_round,
    input  logic               i_final_round,
    output logic [BLOCK_W-1:0] o_state_c,
    output logic [BLOCK_W-1:0] o_rkey_c
);

    logic [BLOCK_W-1:0] w_sub;
    logic [BLOCK_W-1:0] w_shift;
    logic [BLOCK_W-1:0] w_rkey_next;
    logic [31:0]        w_rot;
    logic [31:0]        w_temp;
    logic [31:0]        w_k0, w_k1, w_k2, w_k3;

    // SubBytes then ShiftRows; byte r+4c is row r, column c.
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[BLOCK_W-1-8*i -: 8] = sbox(i_state[BLOCK_W-1-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[BLOCK_W-1-8*(4*c+r) -: 8] = w_sub[BLOCK_W-1-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        w_rot       = {i_rkey[23:0], i_rkey[31:24]};
        w_temp      = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                    ^ {rcon(i_round), 24'h000000};
        w_k0        = i_rkey[127:96] ^ w_temp;
        w_k1        = i_rkey[95:64]  ^ w_k0;
        w_k2        = i_rkey[63:32]  ^ w_k1;
        w_k3        = i_rkey[31:0]   ^ w_k2;
        w_rkey_next = {w_k0, w_k1, w_k2, w_k3};
    end

    assign o_rkey_c  = w_rkey_next;
    assign o_state_c = (i_final_round ? w_shift : mix_columns(w_shift)) ^ w_rkey_next;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: accepts a plaintext/key pair, runs one round per
// clock through a shared round datapath, and holds the ciphertext until taken.
module aes_round_sequencer #(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_round_sequencer_if.slave  bus
);
    import aes_pkg::*;

    fsm_state_e         r_fsm;
    fsm_state_e         w_fsm_next;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] w_round_next;
    logic [BLOCK_W-1:0] r_state;
    logic [BLOCK_W-1:0] w_state_next;
    logic [BLOCK_W-1:0] r_rkey;
    logic [BLOCK_W-1:0] w_rkey_next;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [BLOCK_W-1:0] r_dataout;
    logic [BLOCK_W-1:0] w_step_state_c;
    logic [BLOCK_W-1:0] w_step_rkey_c;
    logic               w_final_c;

    assign w_final_c = (r_round == ROUND_W'(NR));

    aes_round_step u_step (
        .i_state       (r_state),
        .i_rkey        (r_rkey),
        .i_round       (r_round),
        .i_final_round (w_final_c),
        .o_state_c     (w_step_state_c),
        .o_rkey_c      (w_step_rkey_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_round <= '0;
            r_state <= '0;
            r_rkey  <= '0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_round <= w_round_next;
            r_state <= w_state_next;
            r_rkey  <= w_rkey_next;
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_round_next = r_round;
        w_state_next = r_state;
        w_rkey_next  = r_rkey;
        case (r_fsm)
            ST_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_fsm_next   = ST_ROUND;
                    w_round_next = ROUND_W'(1);
                    w_state_next = bus.datain ^ bus.key;
                    w_rkey_next  = bus.key;
                end
            end
            ST_ROUND: begin
                w_state_next = w_step_state_c;
                w_rkey_next  = w_step_rkey_c;
                // Counter parks on the last round instead of wrapping.
                if (w_final_c) begin
                    w_fsm_next = ST_DONE;
                end else begin
                    w_round_next = r_round + ROUND_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_fsm_next = ST_IDLE;
                end
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_dataout   <= '0;
        end else begin
            r_in_ready  <= (w_fsm_next == ST_IDLE);
            r_out_valid <= (w_fsm_next == ST_DONE);
            r_busy      <= (w_fsm_next != ST_IDLE);
            r_dataout   <= (w_fsm_next == ST_DONE) ? w_state_next : '0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.dataout   = r_dataout;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed plus randomized bench for aes_round_sequencer; expected ciphertext
// comes from the FIPS-197 vectors or a byte-array AES model built from GF(2^8) math.
module tb_aes_round_sequencer;

    localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] tb_sbox [256];

    aes_round_sequencer_if bus ();

    aes_round_sequencer #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box derived from the field inverse and the affine map, not a table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = k[127-8*i -: 8];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = tb_sbox[w[i-4+(j+1)%4]];
                tmp[0] = tmp[0] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = tb_sbox[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rnd == 10) ? t[4*c+r]
                             : gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                               ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one block at a negedge, then time and check its result; cycle 0 is
    // the cycle whose closing edge performs the input handshake.
    task automatic run_one(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp,
                           input string tag, input int hold, input logic pulse);
        int guard;
        int lat;
        bus.datain   = pt;
        bus.key      = k;
        bus.in_valid = 1'b1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_bit({tag, " accept"}, bus.in_ready, 1'b1);
        lat = 0;
        @(negedge clk);
        lat = 1;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 30) begin
            if (pulse && lat >= 2 && lat <= 4) begin
                bus.in_valid = 1'b1;
                bus.datain   = ~pt;
                bus.key      = k ^ 128'h1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (lat == 2) check_bit({tag, " in_ready busy"}, bus.in_ready, 1'b0);
            if (lat == 3) check_blk({tag, " dataout hidden"}, bus.dataout, 128'h0);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check_int({tag, " latency"}, lat, 11);
        check_blk({tag, " dataout"}, bus.dataout, exp);
        check_bit({tag, " busy done"}, bus.busy, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_bit({tag, " hold stable"},
                      (bus.dataout === exp) && (bus.out_valid === 1'b1) && (bus.in_ready === 1'b0), 1'b1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_bit({tag, " out_valid drop"}, bus.out_valid, 1'b0);
        check_blk({tag, " dataout clear"}, bus.dataout, 128'h0);
        check_bit({tag, " in_ready back"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] rp;
        logic [127:0] rk;
        logic [127:0] expq [$];
        int           hs_cyc [$];
        int           out_cyc [$];
        int           nhs;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.datain    = '0;
        bus.key       = '0;
        build_sbox();

        // Reset values
        repeat (3) @(negedge clk);
        check_bit("rst in_ready", bus.in_ready, 1'b0);
        check_bit("rst out_valid", bus.out_valid, 1'b0);
        check_bit("rst busy", bus.busy, 1'b0);
        check_blk("rst dataout", bus.dataout, 128'h0);
        rst = 1'b0;
        #1;
        check_bit("in_ready before edge", bus.in_ready, 1'b0);
        @(negedge clk);
        check_bit("in_ready first edge", bus.in_ready, 1'b1);

        // Known-answer vectors, then backpressure
        run_one(V1_PT, V1_KEY, V1_CT, "vec1", 0, 1'b0);
        run_one(V2_PT, V2_KEY, V2_CT, "vec2", 0, 1'b0);
        run_one(V1_PT, V1_KEY, V1_CT, "backpressure", 20, 1'b0);
        run_one(V2_PT, V2_KEY, V2_CT, "after release", 0, 1'b0);

        // Input offered while busy must be dropped
        rp = rand128();
        rk = rand128();
        run_one(rp, rk, ref_encrypt(rp, rk), "ignored input", 0, 1'b1);

        // Random blocks against the reference model
        for (int n = 0; n < 5; n++) begin
            rp = rand128();
            rk = rand128();
            run_one(rp, rk, ref_encrypt(rp, rk), "random", $urandom_range(0, 3), 1'b0);
        end

        // Back-to-back with in_valid and out_ready held high
        nhs = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 48; cyc++) begin
            bus.datain = (nhs % 2 == 0) ? V1_PT : V2_PT;
            bus.key    = (nhs % 2 == 0) ? V1_KEY : V2_KEY;
            if (bus.in_valid && bus.in_ready) begin
                hs_cyc.push_back(cyc);
                expq.push_back((nhs % 2 == 0) ? V1_CT : V2_CT);
                nhs++;
            end
            if (bus.out_valid === 1'b1) begin
                out_cyc.push_back(cyc);
                if (expq.size() > 0) check_blk("b2b dataout", bus.dataout, expq.pop_front());
                else check_bit("b2b unexpected output", 1'b1, 1'b0);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_int("b2b accepts", hs_cyc.size(), 4);
        check_int("b2b outputs", out_cyc.size(), 4);
        for (int i = 1; i < hs_cyc.size(); i++) check_int("b2b interval", hs_cyc[i] - hs_cyc[i-1], 12);
        for (int i = 0; i < out_cyc.size() && i < hs_cyc.size(); i++)
            check_int("b2b latency", out_cyc[i] - hs_cyc[i], 11);
        @(negedge clk);

        // Reset during round 5 aborts the block
        bus.datain   = V1_PT;
        bus.key      = V1_KEY;
        bus.in_valid = 1'b1;
        check_bit("abort accept", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_bit("abort busy before", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("abort out_valid", bus.out_valid, 1'b0);
        check_blk("abort dataout", bus.dataout, 128'h0);
        check_bit("abort busy", bus.busy, 1'b0);
        check_bit("abort in_ready", bus.in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_bit("abort idle after release", bus.busy, 1'b0);
        run_one(V1_PT, V1_KEY, V1_CT, "post abort", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter: NR, 10, number of AES-128 rounds; only 10 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  plaintext and key offered.
REQ-005 in_ready  output  1  sequencer can accept a block.
REQ-006 datain  input  128  plaintext block, byte 0 in bits [127:120].
REQ-007 key  input  128  cipher key, same byte order.
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer accepts the ciphertext.
REQ-010 dataout  output  128  ciphertext block.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL perform FIPS-197 AES-128 encryption iteratively, with one round datapath reused once per cycle and the round key expanded on the fly.
REQ-013 The FSM SHALL have states IDLE, ROUND, and DONE; states SHALL be encoded in a 2-bit enum.
REQ-014 IDLE: in_ready=1. When in_valid is high, the block SHALL load state=datain^key and rkey=key, set round=1, and go to ROUND.
REQ-015 ROUND, each cycle: rkey_next = KeyExpansion step(rkey, Rcon[round]); state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rkey_next); rkey=rkey_next; round increments.
REQ-016 MixColumns SHALL be bypassed when round==NR. After the round NR update the FSM SHALL go to DONE.
REQ-017 round SHALL be a 4-bit counter ranging 1..10; it SHALL never wrap, and the FSM SHALL leave ROUND on 10.
REQ-018 DONE: out_valid=1 and dataout=state, both held stable until out_ready is sampled high; the FSM then returns to IDLE.
REQ-019 Latency SHALL be 11 cycles from the input handshake edge to out_valid high; back-to-back throughput SHALL be one block per 12 cycles.
REQ-020 in_ready SHALL be 0 in ROUND and DONE; in_valid in those states SHALL be ignored, with no queueing.
REQ-021 If out_ready is already high on the cycle DONE is entered, the transfer SHALL complete that cycle, and the next cycle SHALL be IDLE.
REQ-022 dataout SHALL be 0 whenever out_valid is 0, so intermediate state is never exposed.
REQ-023 Rcon SHALL follow the sequence 01,02,04,08,10,20,40,80,1b,36, indexed by round 1..10.

Reset
REQ-024 While rst is high, the block SHALL hold: state=IDLE, round=0, state and rkey registers =0, in_ready=0, out_valid=0, busy=0, dataout=0.
REQ-025 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-026 Reset asserted mid-operation (ROUND or DONE) SHALL abort the block immediately; no partial output SHALL ever be presented.

Structure
REQ-027 A shared package aes_pkg SHALL hold the S-box table, the Rcon table, the xtime/MixColumns functions, the NR constant, and the FSM state enum.
REQ-028 A combinational sub-module aes_round_step SHALL provide the round function plus the key-step, with a final_round input selecting the MixColumns bypass.
REQ-029 The sequencer itself SHALL contain only the FSM, the counter, the handshake logic, and the state/rkey registers.

Verification
REQ-030 Vector 1: key 000102030405060708090a0b0c0d0e0f, datain 00112233445566778899aabbccddeeff -> dataout 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after the handshake.
REQ-031 Vector 2: key 2b7e151628aed2a6abf7158809cf4f3c, datain 3243f6a8885a308d313198a2e0370734 -> dataout 3925841d02dc09fbdc118597196a0b32.
REQ-032 Backpressure: hold out_ready=0 for 20 cycles in DONE -> dataout stays stable, in_ready stays 0; after release, the next block is accepted.
REQ-033 Back-to-back: in_valid held high with out_ready=1 -> blocks are accepted every 12 cycles and both vectors produce correct outputs in order.
REQ-034 Mid-round reset: assert rst during round 5 -> out_valid and dataout go to 0 immediately; after release, vector 1 completes correctly.
REQ-035 Ignored input: pulse in_valid with a different datain while busy -> the result equals the originally accepted block only.
